// File: rtl/fp_op_sequencer.sv
// Issue/completion sequencer for the multi-cycle FP datapath: latches one op,
// holds the FP cores in reset while idle, counts per-opcode latency, captures the result.
module fp_op_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 5,
    parameter int unsigned CNT_WIDTH  = 5,
    parameter int unsigned LAT_ADD    = 6,
    parameter int unsigned LAT_MUL    = 3,
    parameter int unsigned LAT_DIV    = 9,
    parameter int unsigned LAT_SQRT   = 6,
    parameter int unsigned LAT_CMP    = 3,
    parameter int unsigned LAT_CVT_F  = 4,
    parameter int unsigned LAT_CVT_I  = 2,
    parameter int unsigned LAT_SIMPLE = 1
) (
    input  logic                  iclock,
    input  logic                  ireset,
    input  logic                  ivalid,
    output logic                  oready,
    input  logic [OP_WIDTH-1:0]   icontrol,
    input  logic [DATA_WIDTH-1:0] idataa,
    input  logic [DATA_WIDTH-1:0] idatab,
    input  logic                  iflush,
    output logic [OP_WIDTH-1:0]   oop,
    output logic [DATA_WIDTH-1:0] oopa,
    output logic [DATA_WIDTH-1:0] oopb,
    output logic                  ounit_areset,
    input  logic [DATA_WIDTH-1:0] iunit_result,
    output logic [DATA_WIDTH-1:0] oresult,
    output logic                  ovalid,
    input  logic                  iack,
    output logic                  oillegal
);

    // FOP* opcode encodings shared with the FP unit result mux
    localparam logic [OP_WIDTH-1:0] FOPADD    = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] FOPSUB    = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] FOPMUL    = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] FOPDIV    = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] FOPSQRT   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] FOPCEQ    = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] FOPCLT    = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] FOPCLE    = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] FOPCVTSW  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] FOPCVTSWU = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] FOPCVTWS  = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] FOPCVTWUS = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] FOPABS    = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] FOPMV     = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] FOPSGNJ   = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] FOPSGNJN  = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] FOPSGNJX  = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] FOPMAX    = OP_WIDTH'(17);
    localparam logic [OP_WIDTH-1:0] FOPMIN    = OP_WIDTH'(18);
    localparam logic [OP_WIDTH-1:0] FOPNULL   = OP_WIDTH'(19);

    localparam logic [DATA_WIDTH-1:0] ILLEGAL_RESULT = DATA_WIDTH'(32'hEEEE_EEEE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_lat_sel;
    logic [OP_WIDTH-1:0]   r_op;
    logic [DATA_WIDTH-1:0] r_opa;
    logic [DATA_WIDTH-1:0] r_opb;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_valid;
    logic                  r_illegal;
    logic                  r_unit_areset;

    logic [CNT_WIDTH-1:0]  w_lat_sel;
    logic                  w_known_op;
    logic                  w_ready;
    logic                  w_accept;

    always_comb begin
        w_lat_sel  = CNT_WIDTH'(LAT_SIMPLE);
        w_known_op = 1'b1;
        case (icontrol)
            FOPADD, FOPSUB:                 w_lat_sel = CNT_WIDTH'(LAT_ADD);
            FOPMUL:                         w_lat_sel = CNT_WIDTH'(LAT_MUL);
            FOPDIV:                         w_lat_sel = CNT_WIDTH'(LAT_DIV);
            FOPSQRT:                        w_lat_sel = CNT_WIDTH'(LAT_SQRT);
            FOPCEQ, FOPCLT, FOPCLE:         w_lat_sel = CNT_WIDTH'(LAT_CMP);
            FOPCVTSW, FOPCVTSWU:            w_lat_sel = CNT_WIDTH'(LAT_CVT_F);
            FOPCVTWS, FOPCVTWUS:            w_lat_sel = CNT_WIDTH'(LAT_CVT_I);
            FOPABS, FOPMV, FOPSGNJ, FOPSGNJN, FOPSGNJX,
            FOPMAX, FOPMIN, FOPNULL:        w_lat_sel = CNT_WIDTH'(LAT_SIMPLE);
            // Unknown opcodes still run a short dummy cycle so the consumer sees a flagged result
            default:                        w_known_op = 1'b0;
        endcase
    end

    assign w_ready  = ~iflush & ((r_state == S_IDLE) | ((r_state == S_DONE) & iack));
    assign w_accept = ivalid & w_ready;

    always_ff @(posedge iclock) begin
        if (ireset) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_lat_sel     <= '0;
            r_op          <= '0;
            r_opa         <= '0;
            r_opb         <= '0;
            r_result      <= '0;
            r_valid       <= 1'b0;
            r_illegal     <= 1'b0;
            r_unit_areset <= 1'b1;
        end else if (iflush) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_valid       <= 1'b0;
            r_illegal     <= 1'b0;
            r_unit_areset <= 1'b1;
        end else if (w_accept) begin
            // Covers both a fresh issue from IDLE and back-to-back issue on the DONE ack edge
            r_state       <= S_RUN;
            r_count       <= '0;
            r_lat_sel     <= w_lat_sel;
            r_op          <= icontrol;
            r_opa         <= idataa;
            r_opb         <= idatab;
            r_valid       <= 1'b0;
            r_illegal     <= ~w_known_op;
            r_unit_areset <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_count == r_lat_sel) begin
                        r_result      <= r_illegal ? ILLEGAL_RESULT : iunit_result;
                        r_valid       <= 1'b1;
                        r_state       <= S_DONE;
                        r_unit_areset <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_DONE: begin
                    if (iack) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oready       = w_ready;
    assign oop          = r_op;
    assign oopa         = r_opa;
    assign oopb         = r_opb;
    assign oresult      = r_result;
    assign ovalid       = r_valid;
    assign oillegal     = r_illegal;
    assign ounit_areset = r_unit_areset;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Self-checking bench for fp_op_sequencer: opcode table vectors, handshake corner
// sequences and randomized transactions against a latency/result reference model.
module tb_fp_op_sequencer;

    logic        iclock = 1'b0;
    logic        ireset, ivalid, iflush, iack;
    logic        oready, ounit_areset, ovalid, oillegal;
    logic [4:0]  icontrol, oop;
    logic [31:0] idataa, idatab, oopa, oopb, iunit_result, oresult;

    int total = 0;
    int bad   = 0;
    int unsigned lat_tab [32];
    bit          legal_tab [32];
    logic [31:0] exp_last;

    localparam logic [4:0] OADD = 5'd0, OSUB = 5'd1, OMUL = 5'd2, ODIV = 5'd3, OSQRT = 5'd4;
    localparam logic [4:0] OCEQ = 5'd5, OCVTSW = 5'd8, OCVTWS = 5'd10, OMV = 5'd13;
    localparam logic [4:0] OMAX = 5'd17, ONULL = 5'd19;

    fp_op_sequencer #(.DATA_WIDTH(32), .OP_WIDTH(5), .CNT_WIDTH(5)) dut (
        .iclock(iclock), .ireset(ireset), .ivalid(ivalid), .oready(oready),
        .icontrol(icontrol), .idataa(idataa), .idatab(idatab), .iflush(iflush),
        .oop(oop), .oopa(oopa), .oopb(oopb), .ounit_areset(ounit_areset),
        .iunit_result(iunit_result), .oresult(oresult), .ovalid(ovalid),
        .iack(iack), .oillegal(oillegal)
    );

    always #5 iclock = ~iclock;

    // Stand-in for the FP unit mux: deterministic per (op, a, b)
    function automatic logic [31:0] stub(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == OADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + ({27'd0, op} * 32'h0101_0101);
    endfunction

    always_comb iunit_result = stub(oop, oopa, oopb);

    function automatic logic [31:0] model_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        return legal_tab[op] ? stub(op, a, b) : 32'hEEEE_EEEE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iclock);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        icontrol = op; idataa = a; idatab = b; ivalid = 1'b1;
        #1;
        chk("issue_oready", {31'd0, oready}, 32'd1);
        step();
        ivalid = 1'b0; icontrol = 5'($urandom); idataa = $urandom; idatab = $urandom;
    endtask

    // Edges counted from the accept edge until ovalid rises; inputs optionally jittered while running
    task automatic wait_valid(input bit noise, output int n);
        n = 0;
        while (ovalid !== 1'b1 && n < 40) begin
            if (noise) begin
                iack = 1'($urandom); ivalid = 1'($urandom); icontrol = 5'($urandom);
            end
            step();
            n++;
        end
        iack = 1'b0; ivalid = 1'b0;
    endtask

    task automatic ack_result();
        iack = 1'b1;
        step();
        iack = 1'b0;
        chk("ack_ovalid", {31'd0, ovalid}, 32'd0);
        chk("ack_oready", {31'd0, oready}, 32'd1);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          edges;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    initial begin
        vec_t vecs [12];
        int n;
        logic [31:0] held;
        bit seen;

        for (int unsigned i = 0; i < 32; i++) begin
            legal_tab[i] = (i <= 19);
            lat_tab[i]   = 1;
        end
        lat_tab[0] = 6; lat_tab[1] = 6; lat_tab[2] = 3; lat_tab[3] = 9; lat_tab[4] = 6;
        lat_tab[5] = 3; lat_tab[6] = 3; lat_tab[7] = 3; lat_tab[8] = 4; lat_tab[9] = 4;
        lat_tab[10] = 2; lat_tab[11] = 2;

        vecs[0]  = '{OADD,   32'h3F80_0000, 32'h4000_0000, 7,  32'h4040_0000, 1'b0};
        vecs[1]  = '{OSUB,   32'h1234_5678, 32'h9ABC_DEF0, 7,  '0, 1'b0};
        vecs[2]  = '{OMUL,   32'hDEAD_BEEF, 32'h0000_0001, 4,  '0, 1'b0};
        vecs[3]  = '{ODIV,   32'hFFFF_FFFF, 32'h8000_0000, 10, '0, 1'b0};
        vecs[4]  = '{OSQRT,  32'h4080_0000, 32'h0,         7,  '0, 1'b0};
        vecs[5]  = '{OCEQ,   32'hA5A5_A5A5, 32'h5A5A_5A5A, 4,  '0, 1'b0};
        vecs[6]  = '{OCVTSW, 32'h0000_0007, 32'h1111_1111, 5,  '0, 1'b0};
        vecs[7]  = '{OCVTWS, 32'h4120_0000, 32'h2222_2222, 3,  '0, 1'b0};
        vecs[8]  = '{OMV,    32'h0BAD_F00D, 32'h3333_3333, 2,  '0, 1'b0};
        vecs[9]  = '{OMAX,   32'h7F7F_FFFF, 32'hFF7F_FFFF, 2,  '0, 1'b0};
        vecs[10] = '{ONULL,  32'h0,         32'h0,         2,  '0, 1'b0};
        vecs[11] = '{5'd25,  32'h4444_4444, 32'h5555_5555, 2,  32'hEEEE_EEEE, 1'b1};
        for (int i = 1; i < 11; i++) vecs[i].res = stub(vecs[i].op, vecs[i].a, vecs[i].b);

        ireset = 1'b1; ivalid = 1'b0; iflush = 1'b0; iack = 1'b0;
        icontrol = '0; idataa = '0; idatab = '0;
        step(); step();
        chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
        chk("rst_oresult", oresult, 32'd0);
        chk("rst_oop", {27'd0, oop}, 32'd0);
        chk("rst_oopa", oopa, 32'd0);
        chk("rst_oillegal", {31'd0, oillegal}, 32'd0);
        chk("rst_areset", {31'd0, ounit_areset}, 32'd1);
        ireset = 1'b0;
        #1;
        chk("rst_oready", {31'd0, oready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            chk("run_areset", {31'd0, ounit_areset}, 32'd0);
            chk("run_oready", {31'd0, oready}, 32'd0);
            wait_valid(1'b1, n);
            chk("vec_latency", n, vecs[i].edges);
            chk("vec_result", oresult, vecs[i].res);
            chk("vec_illegal", {31'd0, oillegal}, {31'd0, vecs[i].ill});
            chk("vec_oop", {27'd0, oop}, {27'd0, vecs[i].op});
            chk("vec_oopa", oopa, vecs[i].a);
            chk("vec_oopb", oopb, vecs[i].b);
            chk("done_areset", {31'd0, ounit_areset}, 32'd1);
            ack_result();
        end

        // Result held while the consumer stalls
        issue(OMV, 32'hCAFE_0001, 32'h0000_0002);
        wait_valid(1'b0, n);
        chk("mv_latency", n, 2);
        held = oresult;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid_result", {ovalid, oresult[30:0]}, {1'b1, held[30:0]});
        end
        chk("hold_result", oresult, stub(OMV, 32'hCAFE_0001, 32'h0000_0002));

        // Back-to-back issue on the ack edge
        iack = 1'b1; ivalid = 1'b1; icontrol = OMUL; idataa = 32'h4000_0000; idatab = 32'h4040_0000;
        #1;
        chk("b2b_oready", {31'd0, oready}, 32'd1);
        step();
        iack = 1'b0; ivalid = 1'b0;
        chk("b2b_ovalid_drop", {31'd0, ovalid}, 32'd0);
        chk("b2b_oop", {27'd0, oop}, {27'd0, OMUL});
        wait_valid(1'b0, n);
        chk("b2b_latency", n, 4);
        chk("b2b_result", oresult, stub(OMUL, 32'h4000_0000, 32'h4040_0000));
        exp_last = oresult == stub(OMUL, 32'h4000_0000, 32'h4040_0000) ? oresult : 32'hX;
        exp_last = stub(OMUL, 32'h4000_0000, 32'h4040_0000);
        ack_result();

        // Flush a DIV at count 4
        issue(ODIV, 32'h1, 32'h2);
        repeat (4) step();
        iflush = 1'b1;
        #1;
        chk("flush_oready_low", {31'd0, oready}, 32'd0);
        step();
        iflush = 1'b0;
        #1;
        chk("flush_areset", {31'd0, ounit_areset}, 32'd1);
        chk("flush_oready", {31'd0, oready}, 32'd1);
        seen = 1'b0;
        repeat (12) begin
            if (ovalid !== 1'b0) seen = 1'b1;
            step();
        end
        chk("flush_no_valid", {31'd0, seen}, 32'd0);
        chk("flush_oresult_kept", oresult, exp_last);

        // Illegal opcode, then cleared by next accept
        issue(5'd31, 32'h1, 32'h1);
        chk("ill_flag_run", {31'd0, oillegal}, 32'd1);
        wait_valid(1'b0, n);
        chk("ill_latency", n, 2);
        chk("ill_result", oresult, 32'hEEEE_EEEE);
        ack_result();
        issue(OADD, 32'h3F80_0000, 32'h4000_0000);
        chk("ill_cleared", {31'd0, oillegal}, 32'd0);
        wait_valid(1'b0, n);
        ack_result();

        // Reset mid-run, then a clean SQRT
        issue(OSQRT, 32'h4080_0000, 32'h0);
        step(); step();
        ireset = 1'b1;
        step();
        ireset = 1'b0;
        chk("midrst_state", {oresult[15:0], 7'd0, ovalid, oillegal, ounit_areset, oop, 1'b0},
            {16'd0, 7'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0});
        chk("midrst_oresult", oresult, 32'd0);
        chk("midrst_oopa", oopa, 32'd0);
        exp_last = 32'd0;
        issue(OSQRT, 32'h4080_0000, 32'h0);
        wait_valid(1'b0, n);
        chk("sqrt_latency", n, 7);
        chk("sqrt_result", oresult, stub(OSQRT, 32'h4080_0000, 32'h0));
        exp_last = stub(OSQRT, 32'h4080_0000, 32'h0);
        ack_result();

        // Randomized transactions against the latency/result model
        for (int t = 0; t < 60; t++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            int unsigned k;
            op = 5'($urandom_range(0, 31));
            a = $urandom; b = $urandom;
            repeat ($urandom_range(0, 2)) step();
            issue(op, a, b);
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, lat_tab[op]);
                repeat (k) step();
                iflush = 1'b1;
                step();
                iflush = 1'b0;
                chk("rnd_flush_ovalid", {31'd0, ovalid}, 32'd0);
                chk("rnd_flush_oresult", oresult, exp_last);
            end else begin
                wait_valid(1'b1, n);
                chk("rnd_latency", n, int'(lat_tab[op]) + 1);
                chk("rnd_result", oresult, model_result(op, a, b));
                chk("rnd_illegal", {31'd0, oillegal}, {31'd0, !legal_tab[op]});
                chk("rnd_oop", {27'd0, oop}, {27'd0, op});
                exp_last = model_result(op, a, b);
                repeat ($urandom_range(0, 3)) step();
                chk("rnd_held", {ovalid, oresult[30:0]}, {1'b1, exp_last[30:0]});
                ack_result();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
